axi4_lite_fanin: RTL and testbench
==================================

AXI4_LITE_FANIN -- requirements
Module: axi4_lite_fanin

Interface
REQ-001 Parameter CONFIG, default '{default: 0, A: 16, N: 4}, axi4_lite_cfg_t; A = address width, N = data bytes.
REQ-002 Parameter S, default 2, number of upstream initiators; legal range 2..8.
REQ-003 aclk  input  1  single clock; all state changes on rising edge.
REQ-004 aresetn  input  1  reset, asynchronous assert, active-low.
REQ-005 axi4_s[S]  axi4_lite_if(CONFIG) slave modport  upstream initiator ports, index 0..S-1.
REQ-006 axi4_m  axi4_lite_if(CONFIG) master modport  single downstream target port.

Function
REQ-007 Write path (AW/W/B) and read path (AR/R) shall arbitrate independently and may be busy at the same time for different or the same initiators.
REQ-008 Write FSM states: W_IDLE, W_XFER, W_RESP; read FSM states: R_IDLE, R_ADDR, R_DATA.
REQ-009 A write request is axi4_s[i].awvalid = 1; wvalid alone shall not request.
REQ-010 A read request is axi4_s[i].arvalid = 1.
REQ-011 In W_IDLE with at least one request: register grant wgnt = first requester at or after pointer wptr, in increasing index with wrap S-1 -> 0, then go to W_XFER.
REQ-012 In W_XFER: forward awaddr/awprot/awvalid and wdata/wstrb/wvalid of axi4_s[wgnt] to axi4_m, and return awready/wready to axi4_s[wgnt] only.
REQ-013 The AW and W handshakes may complete in either order or in the same cycle; the FSM shall go to W_RESP after both have completed.
REQ-014 In W_RESP: forward bvalid/bresp to axi4_s[wgnt] and bready from it.
REQ-015 On the B handshake: go to W_IDLE and set wptr = (wgnt+1) mod S.
REQ-016 In R_IDLE: same round-robin selection using rptr, giving rgnt, then go to R_ADDR.
REQ-017 R_ADDR shall forward AR of axi4_s[rgnt] and go to R_DATA on the AR handshake.
REQ-018 R_DATA shall forward rvalid/rdata/rresp to axi4_s[rgnt] and rready from it.
REQ-019 On the R handshake: go to R_IDLE and set rptr = (rgnt+1) mod S.
REQ-020 Non-granted initiators shall see awready = wready = arready = bvalid = rvalid = 0.
REQ-021 In IDLE states, all axi4_m valid outputs shall be 0.
REQ-022 Arbitration latency is exactly one cycle: a request seen in IDLE appears on axi4_m the next cycle.
REQ-023 Exactly one transaction is outstanding per path.
REQ-024 Once granted, a request shall not be withdrawn or re-arbitrated until its response handshake completes.
REQ-025 An upstream valid held under downstream backpressure shall keep its payload; payload passes through combinationally from the granted port.
REQ-026 A response channel stalled by ready = 0 shall hold the FSM state indefinitely.
REQ-027 Simultaneous requests are resolved solely by pointer order.
REQ-028 No initiator shall be starved; worst-case wait is S-1 transactions.

Reset
REQ-029 While aresetn = 0: write FSM = W_IDLE, read FSM = R_IDLE, wptr = rptr = 0, wgnt = rgnt = 0.
REQ-030 While aresetn = 0: all axi4_m valid/ready outputs and all axi4_s valid/ready outputs shall be 0.
REQ-031 Reset asserted mid-transaction shall abandon it immediately with no completion to either side.
REQ-032 First grants after reset release shall occur no earlier than the first rising edge with aresetn = 1.

Verification
REQ-033 S=2, target = axi4_lite_register_file (A=16, N=4): initiator 0 writes 0x04 <- 0xabba_beef, initiator 1 reads 0x04 -> 0xabba_beef with rresp OKAY.
REQ-034 After reset, both initiators assert awvalid in the same cycle -> initiator 0 completes B first, then initiator 1.
REQ-035 A second simultaneous pair after REQ-034 -> initiator 0 is granted first again, because wptr has wrapped to 0.
REQ-036 Initiator 0 writes while initiator 1 reads concurrently -> both paths overlap on axi4_m and each response reaches only its requester.
REQ-037 Initiator 0 holds bready = 0 for 10 cycles -> initiator 1's pending awvalid sees awready = 0 until the B handshake, then its write completes.
REQ-038 aresetn pulsed low while in W_XFER -> all valids go to 0 asynchronously; after release, a fresh write to 0x08 from initiator 1 completes normally.

Source files
------------

// File: rtl/axi4_lite_fanin_if.sv
// AXI4-Lite configuration package and channel bundle.
// One interface instance carries all five channels of a single link.
package axi4_lite_pkg;

    typedef struct packed {
        int unsigned A;
        int unsigned N;
    } axi4_lite_cfg_t;

endpackage

interface axi4_lite_if
    import axi4_lite_pkg::*;
#(
    parameter axi4_lite_cfg_t CONFIG = '{default: 0, A: 16, N: 4}
) ();

    localparam int AW = int'(CONFIG.A);
    localparam int SW = int'(CONFIG.N);
    localparam int DW = 8 * SW;

    logic          awvalid;
    logic          awready;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;

    logic          wvalid;
    logic          wready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;

    logic          bvalid;
    logic          bready;
    logic [1:0]    bresp;

    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;

    logic          rvalid;
    logic          rready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;

    modport master (
        output awvalid, awaddr, awprot,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr, arprot,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awprot,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr, arprot,
        output arready,
        output rvalid, rdata, rresp,
        input  rready
    );

endinterface

// File: rtl/axi4_lite_fanin.sv
// S-to-1 AXI4-Lite fan-in with independent round-robin
// arbitration of the write (AW/W/B) and read (AR/R) paths.
module axi4_lite_fanin
    import axi4_lite_pkg::*;
#(
    parameter axi4_lite_cfg_t CONFIG = '{default: 0, A: 16, N: 4},
    parameter int             S      = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    axi4_lite_if.slave  axi4_s [S],
    axi4_lite_if.master axi4_m
);

    localparam int AW = int'(CONFIG.A);
    localparam int SW = int'(CONFIG.N);
    localparam int DW = 8 * SW;
    localparam int IW = (S > 1) ? $clog2(S) : 1;
    localparam int SP = 1 << IW;

    typedef enum logic [1:0] {
        W_IDLE,
        W_XFER,
        W_RESP
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rstate_t;

    // Per-port views padded to a power of two so grant indexing stays in range
    logic [SP-1:0] s_awvalid;
    logic [SP-1:0] s_wvalid;
    logic [SP-1:0] s_bready;
    logic [SP-1:0] s_arvalid;
    logic [SP-1:0] s_rready;
    logic [AW-1:0] s_awaddr [SP];
    logic [2:0]    s_awprot [SP];
    logic [DW-1:0] s_wdata  [SP];
    logic [SW-1:0] s_wstrb  [SP];
    logic [AW-1:0] s_araddr [SP];
    logic [2:0]    s_arprot [SP];

    logic [SP-1:0] g_awready;
    logic [SP-1:0] g_wready;
    logic [SP-1:0] g_bvalid;
    logic [SP-1:0] g_arready;
    logic [SP-1:0] g_rvalid;

    wstate_t       wstate, wstate_n;
    rstate_t       rstate, rstate_n;
    logic [IW-1:0] wgnt, wgnt_n;
    logic [IW-1:0] wptr, wptr_n;
    logic [IW-1:0] rgnt, rgnt_n;
    logic [IW-1:0] rptr, rptr_n;
    logic          aw_done, aw_done_n;
    logic          w_done, w_done_n;

    logic          m_awvalid;
    logic          m_wvalid;
    logic          m_bready;
    logic          m_arvalid;
    logic          m_rready;
    logic          aw_hs;
    logic          w_hs;

    function automatic logic [IW-1:0] next_idx(
        input logic [IW-1:0] idx
    );
        return (idx == IW'(S - 1)) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [IW-1:0] rr_pick(
        input logic [SP-1:0] req,
        input logic [IW-1:0] ptr
    );
        logic [IW-1:0] idx;
        logic [IW-1:0] pick;
        logic          found;
        idx   = ptr;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < S; k++) begin
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = next_idx(idx);
        end
        return pick;
    endfunction

    for (genvar i = 0; i < SP; i++) begin : g_port
        if (i < S) begin : g_real
            assign s_awvalid[i] = axi4_s[i].awvalid;
            assign s_wvalid[i]  = axi4_s[i].wvalid;
            assign s_bready[i]  = axi4_s[i].bready;
            assign s_arvalid[i] = axi4_s[i].arvalid;
            assign s_rready[i]  = axi4_s[i].rready;
            assign s_awaddr[i]  = axi4_s[i].awaddr;
            assign s_awprot[i]  = axi4_s[i].awprot;
            assign s_wdata[i]   = axi4_s[i].wdata;
            assign s_wstrb[i]   = axi4_s[i].wstrb;
            assign s_araddr[i]  = axi4_s[i].araddr;
            assign s_arprot[i]  = axi4_s[i].arprot;

            assign axi4_s[i].awready = g_awready[i];
            assign axi4_s[i].wready  = g_wready[i];
            assign axi4_s[i].bvalid  = g_bvalid[i];
            assign axi4_s[i].bresp   = axi4_m.bresp;
            assign axi4_s[i].arready = g_arready[i];
            assign axi4_s[i].rvalid  = g_rvalid[i];
            assign axi4_s[i].rdata   = axi4_m.rdata;
            assign axi4_s[i].rresp   = axi4_m.rresp;
        end else begin : g_pad
            assign s_awvalid[i] = 1'b0;
            assign s_wvalid[i]  = 1'b0;
            assign s_bready[i]  = 1'b0;
            assign s_arvalid[i] = 1'b0;
            assign s_rready[i]  = 1'b0;
            assign s_awaddr[i]  = '0;
            assign s_awprot[i]  = '0;
            assign s_wdata[i]   = '0;
            assign s_wstrb[i]   = '0;
            assign s_araddr[i]  = '0;
            assign s_arprot[i]  = '0;
        end
    end

    assign axi4_m.awvalid = m_awvalid;
    assign axi4_m.awaddr  = s_awaddr[wgnt];
    assign axi4_m.awprot  = s_awprot[wgnt];
    assign axi4_m.wvalid  = m_wvalid;
    assign axi4_m.wdata   = s_wdata[wgnt];
    assign axi4_m.wstrb   = s_wstrb[wgnt];
    assign axi4_m.bready  = m_bready;
    assign axi4_m.arvalid = m_arvalid;
    assign axi4_m.araddr  = s_araddr[rgnt];
    assign axi4_m.arprot  = s_arprot[rgnt];
    assign axi4_m.rready  = m_rready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate  <= W_IDLE;
            wgnt    <= '0;
            wptr    <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rstate  <= R_IDLE;
            rgnt    <= '0;
            rptr    <= '0;
        end else begin
            wstate  <= wstate_n;
            wgnt    <= wgnt_n;
            wptr    <= wptr_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
            rstate  <= rstate_n;
            rgnt    <= rgnt_n;
            rptr    <= rptr_n;
        end
    end

    // AW and W are tracked separately so they may finish in any order
    always_comb begin
        wstate_n  = wstate;
        wgnt_n    = wgnt;
        wptr_n    = wptr;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        g_awready = '0;
        g_wready  = '0;
        g_bvalid  = '0;
        unique case (wstate)
            W_IDLE: begin
                if (|s_awvalid) begin
                    wgnt_n    = rr_pick(s_awvalid, wptr);
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                    wstate_n  = W_XFER;
                end
            end
            W_XFER: begin
                m_awvalid       = s_awvalid[wgnt] & ~aw_done;
                m_wvalid        = s_wvalid[wgnt] & ~w_done;
                g_awready[wgnt] = axi4_m.awready & ~aw_done;
                g_wready[wgnt]  = axi4_m.wready & ~w_done;
                aw_hs           = m_awvalid & axi4_m.awready;
                w_hs            = m_wvalid & axi4_m.wready;
                if (aw_hs) begin
                    aw_done_n = 1'b1;
                end
                if (w_hs) begin
                    w_done_n = 1'b1;
                end
                if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                    wstate_n = W_RESP;
                end
            end
            W_RESP: begin
                m_bready       = s_bready[wgnt];
                g_bvalid[wgnt] = axi4_m.bvalid;
                if (axi4_m.bvalid && s_bready[wgnt]) begin
                    wptr_n   = next_idx(wgnt);
                    wstate_n = W_IDLE;
                end
            end
            default: begin
                wstate_n = W_IDLE;
            end
        endcase
    end

    always_comb begin
        rstate_n  = rstate;
        rgnt_n    = rgnt;
        rptr_n    = rptr;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        g_arready = '0;
        g_rvalid  = '0;
        unique case (rstate)
            R_IDLE: begin
                if (|s_arvalid) begin
                    rgnt_n   = rr_pick(s_arvalid, rptr);
                    rstate_n = R_ADDR;
                end
            end
            R_ADDR: begin
                m_arvalid       = s_arvalid[rgnt];
                g_arready[rgnt] = axi4_m.arready;
                if (m_arvalid && axi4_m.arready) begin
                    rstate_n = R_DATA;
                end
            end
            R_DATA: begin
                m_rready       = s_rready[rgnt];
                g_rvalid[rgnt] = axi4_m.rvalid;
                if (axi4_m.rvalid && s_rready[rgnt]) begin
                    rptr_n   = next_idx(rgnt);
                    rstate_n = R_IDLE;
                end
            end
            default: begin
                rstate_n = R_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi4_lite_fanin.sv
// Bench for axi4_lite_fanin: two initiators in front of a
// small behavioural AXI4-Lite register-file target.
module tb_axi4_lite_fanin;
    import axi4_lite_pkg::*;

    localparam axi4_lite_cfg_t CFG = '{default: 0, A: 16, N: 4};

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi4_lite_if #(.CONFIG(CFG)) s_if [2] ();
    axi4_lite_if #(.CONFIG(CFG)) m_if ();

    axi4_lite_fanin #(.CONFIG(CFG), .S(2)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .axi4_s  (s_if),
        .axi4_m  (m_if)
    );

    logic [1:0]  awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic [15:0] awaddr_d [2];
    logic [15:0] araddr_d [2];
    logic [31:0] wdata_d  [2];
    logic [3:0]  wstrb_d  [2];
    logic [1:0]  awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]  bresp_q [2];
    logic [1:0]  rresp_q [2];
    logic [31:0] rdata_q [2];

    for (genvar k = 0; k < 2; k++) begin : g_up
        assign s_if[k].awvalid = awvalid_d[k];
        assign s_if[k].awaddr  = awaddr_d[k];
        assign s_if[k].awprot  = 3'b000;
        assign s_if[k].wvalid  = wvalid_d[k];
        assign s_if[k].wdata   = wdata_d[k];
        assign s_if[k].wstrb   = wstrb_d[k];
        assign s_if[k].bready  = bready_d[k];
        assign s_if[k].arvalid = arvalid_d[k];
        assign s_if[k].araddr  = araddr_d[k];
        assign s_if[k].arprot  = 3'b000;
        assign s_if[k].rready  = rready_d[k];
        assign awready_q[k] = s_if[k].awready;
        assign wready_q[k]  = s_if[k].wready;
        assign bvalid_q[k]  = s_if[k].bvalid;
        assign arready_q[k] = s_if[k].arready;
        assign rvalid_q[k]  = s_if[k].rvalid;
        assign bresp_q[k]   = s_if[k].bresp;
        assign rresp_q[k]   = s_if[k].rresp;
        assign rdata_q[k]   = s_if[k].rdata;
    end

    // Behavioural register-file target, 16 words
    logic        stall = 1'b0;
    logic [31:0] mem [16];
    logic        aw_got, w_got, t_bvalid, t_rvalid;
    logic [15:0] t_awaddr;
    logic [31:0] t_wdata, t_rdata;
    logic [3:0]  t_wstrb;
    logic        t_awready, t_wready, t_arready;

    assign t_awready = !aw_got && !t_bvalid && !stall;
    assign t_wready  = !w_got && !t_bvalid && !stall;
    assign t_arready = !t_rvalid && !stall;
    assign m_if.awready = t_awready;
    assign m_if.wready  = t_wready;
    assign m_if.bvalid  = t_bvalid;
    assign m_if.bresp   = 2'b00;
    assign m_if.arready = t_arready;
    assign m_if.rvalid  = t_rvalid;
    assign m_if.rdata   = t_rdata;
    assign m_if.rresp   = 2'b00;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            t_bvalid <= 1'b0;
            t_rvalid <= 1'b0;
            t_awaddr <= '0;
            t_wdata  <= '0;
            t_wstrb  <= '0;
            t_rdata  <= '0;
            for (int k = 0; k < 16; k++) mem[k] <= '0;
        end else begin
            if (m_if.awvalid && t_awready) begin
                aw_got   <= 1'b1;
                t_awaddr <= m_if.awaddr;
            end
            if (m_if.wvalid && t_wready) begin
                w_got   <= 1'b1;
                t_wdata <= m_if.wdata;
                t_wstrb <= m_if.wstrb;
            end
            if (aw_got && w_got && !t_bvalid) begin
                for (int b = 0; b < 4; b++)
                    if (t_wstrb[b])
                        mem[t_awaddr[5:2]][8*b +: 8] <= t_wdata[8*b +: 8];
                t_bvalid <= 1'b1;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
            end
            if (t_bvalid && m_if.bready) t_bvalid <= 1'b0;
            if (m_if.arvalid && t_arready) begin
                t_rvalid <= 1'b1;
                t_rdata  <= mem[m_if.araddr[5:2]];
            end
            if (t_rvalid && m_if.rready) t_rvalid <= 1'b0;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int stray = 0;
    int leak = 0;
    int ovl = 0;
    logic [1:0] wbusy = '0;
    logic [1:0] rbusy = '0;
    logic watch1 = 1'b0;
    logic ovl_on = 1'b0;
    logic [9:0] quiet;

    assign quiet = {m_if.awvalid, m_if.wvalid, m_if.arvalid,
                    m_if.bready, m_if.rready, |awready_q, |wready_q,
                    |arready_q, |bvalid_q, |rvalid_q};

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (aresetn) begin
            for (int k = 0; k < 2; k++)
                if ((bvalid_q[k] && !wbusy[k]) || (awready_q[k] && !wbusy[k]) ||
                    (rvalid_q[k] && !rbusy[k]) || (arready_q[k] && !rbusy[k]))
                    stray <= stray + 1;
            if (watch1 && awready_q[1]) leak <= leak + 1;
            if (ovl_on && (m_if.awvalid || m_if.wvalid) &&
                (m_if.arvalid || m_if.rvalid))
                ovl <= ovl + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic write_txn(input int i, input logic [15:0] a,
                             input logic [31:0] d, input logic [3:0] st,
                             input int bdelay, output logic [1:0] resp,
                             output int tdone, output bit ok);
        bit haw, hw, hb;
        int waitb;
        wbusy[i] = 1'b1;
        awaddr_d[i] = a;
        wdata_d[i] = d;
        wstrb_d[i] = st;
        awvalid_d[i] = 1'b1;
        wvalid_d[i] = 1'b1;
        bready_d[i] = (bdelay == 0);
        ok = 0;
        waitb = 0;
        tdone = 0;
        resp = 2'b11;
        for (int n = 0; n < 200; n++) begin
            haw = awvalid_d[i] && awready_q[i];
            hw = wvalid_d[i] && wready_q[i];
            hb = bvalid_q[i] && bready_d[i];
            if (bvalid_q[i]) resp = bresp_q[i];
            @(posedge aclk);
            #1;
            if (haw) awvalid_d[i] = 1'b0;
            if (hw) wvalid_d[i] = 1'b0;
            if (hb) begin
                ok = 1;
                tdone = cyc;
                break;
            end
            if (bvalid_q[i] && !bready_d[i]) begin
                waitb++;
                if (waitb >= bdelay) bready_d[i] = 1'b1;
            end
        end
        awvalid_d[i] = 1'b0;
        wvalid_d[i] = 1'b0;
        bready_d[i] = 1'b0;
        wbusy[i] = 1'b0;
    endtask

    task automatic read_txn(input int i, input logic [15:0] a,
                            output logic [31:0] d, output logic [1:0] resp,
                            output int tdone, output bit ok);
        bit har, hr;
        rbusy[i] = 1'b1;
        araddr_d[i] = a;
        arvalid_d[i] = 1'b1;
        rready_d[i] = 1'b1;
        ok = 0;
        d = '0;
        resp = 2'b11;
        tdone = 0;
        for (int n = 0; n < 200; n++) begin
            har = arvalid_d[i] && arready_q[i];
            hr = rvalid_q[i];
            if (hr) begin
                d = rdata_q[i];
                resp = rresp_q[i];
            end
            @(posedge aclk);
            #1;
            if (har) arvalid_d[i] = 1'b0;
            if (hr) begin
                ok = 1;
                tdone = cyc;
                break;
            end
        end
        arvalid_d[i] = 1'b0;
        rready_d[i] = 1'b0;
        rbusy[i] = 1'b0;
    endtask

    typedef struct {
        int          init;
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [11];

    initial begin
        logic [1:0]  r0, r1;
        logic [31:0] d0, d1;
        int          t0, t1, ts;
        bit          ok0, ok1;

        vt[0]  = '{0, 1'b1, 16'h0004, 32'habba_beef, 4'hf, 32'h0};
        vt[1]  = '{1, 1'b0, 16'h0004, 32'h0, 4'h0, 32'habba_beef};
        vt[2]  = '{1, 1'b1, 16'h000c, 32'h1234_5678, 4'hf, 32'h0};
        vt[3]  = '{0, 1'b0, 16'h000c, 32'h0, 4'h0, 32'h1234_5678};
        vt[4]  = '{0, 1'b1, 16'h0004, 32'h0000_5555, 4'h3, 32'h0};
        vt[5]  = '{1, 1'b0, 16'h0004, 32'h0, 4'h0, 32'habba_5555};
        vt[6]  = '{1, 1'b1, 16'h0004, 32'h7700_0000, 4'h8, 32'h0};
        vt[7]  = '{0, 1'b0, 16'h0004, 32'h0, 4'h0, 32'h77ba_5555};
        vt[8]  = '{0, 1'b0, 16'h0010, 32'h0, 4'h0, 32'h3333_3333};
        vt[9]  = '{1, 1'b0, 16'h0014, 32'h0, 4'h0, 32'h4444_4444};
        vt[10] = '{0, 1'b0, 16'h0000, 32'h0, 4'h0, 32'h0};

        awvalid_d = '0; wvalid_d = '0; bready_d = '0;
        arvalid_d = '0; rready_d = '0;
        for (int k = 0; k < 2; k++) begin
            awaddr_d[k] = '0; araddr_d[k] = '0;
            wdata_d[k] = '0; wstrb_d[k] = '0;
        end

        awvalid_d[0] = 1'b1;
        arvalid_d[1] = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("reset_quiet", quiet, 10'd0);
        awvalid_d = '0;
        arvalid_d = '0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        fork
            write_txn(0, 16'h0010, 32'h1111_1111, 4'hf, 0, r0, t0, ok0);
            write_txn(1, 16'h0014, 32'h2222_2222, 4'hf, 0, r1, t1, ok1);
        join
        chk("pair1_done", {ok0, ok1}, 2'b11);
        chk("pair1_resp", {r0, r1}, 4'b0000);
        chk("pair1_order", t0 < t1, 1'b1);

        fork
            write_txn(0, 16'h0010, 32'h3333_3333, 4'hf, 0, r0, t0, ok0);
            write_txn(1, 16'h0014, 32'h4444_4444, 4'hf, 0, r1, t1, ok1);
        join
        chk("pair2_done", {ok0, ok1}, 2'b11);
        chk("pair2_order", t0 < t1, 1'b1);

        for (int v = 0; v < 11; v++) begin
            if (vt[v].wr) begin
                write_txn(vt[v].init, vt[v].addr, vt[v].data, vt[v].strb,
                          0, r0, t0, ok0);
                chk($sformatf("vec%0d_wr", v), {ok0, r0}, {1'b1, 2'b00});
            end else begin
                read_txn(vt[v].init, vt[v].addr, d0, r0, t0, ok0);
                chk($sformatf("vec%0d_rd", v), {ok0, r0, d0},
                    {1'b1, 2'b00, vt[v].exp});
            end
        end

        ovl_on = 1'b1;
        fork
            write_txn(0, 16'h0018, 32'hcafe_f00d, 4'hf, 0, r0, t0, ok0);
            read_txn(1, 16'h000c, d1, r1, t1, ok1);
        join
        ovl_on = 1'b0;
        chk("conc_wr", {ok0, r0}, {1'b1, 2'b00});
        chk("conc_rd", {ok1, r1, d1}, {1'b1, 2'b00, 32'h1234_5678});
        chk("conc_overlap", ovl > 0, 1'b1);
        read_txn(1, 16'h0018, d1, r1, t1, ok1);
        chk("conc_readback", {ok1, d1}, {1'b1, 32'hcafe_f00d});

        ts = cyc;
        watch1 = 1'b1;
        fork
            begin
                write_txn(0, 16'h001c, 32'h5a5a_0001, 4'hf, 10, r0, t0, ok0);
                watch1 = 1'b0;
            end
            begin
                @(posedge aclk);
                #1;
                write_txn(1, 16'h0024, 32'h5a5a_0002, 4'hf, 0, r1, t1, ok1);
            end
        join
        chk("stall_done", {ok0, ok1}, 2'b11);
        chk("stall_hold", (t0 - ts) >= 10, 1'b1);
        chk("stall_leak", leak, 0);
        chk("stall_order", t0 < t1, 1'b1);

        stall = 1'b1;
        awaddr_d[0] = 16'h0020;
        wdata_d[0] = 32'hdead_0020;
        wstrb_d[0] = 4'hf;
        awvalid_d[0] = 1'b1;
        wvalid_d[0] = 1'b1;
        chk("lat_idle", m_if.awvalid, 1'b0);
        @(posedge aclk);
        #1;
        chk("lat_grant", {m_if.awvalid, m_if.wvalid, m_if.awaddr},
            {1'b1, 1'b1, 16'h0020});
        #2;
        aresetn = 1'b0;
        #1;
        chk("rst_async_quiet", quiet, 10'd0);
        awvalid_d[0] = 1'b0;
        wvalid_d[0] = 1'b0;
        stall = 1'b0;
        repeat (2) @(posedge aclk);
        #3;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        write_txn(1, 16'h0008, 32'h0bad_cafe, 4'hf, 0, r1, t1, ok1);
        chk("post_rst_wr", {ok1, r1}, {1'b1, 2'b00});
        read_txn(0, 16'h0008, d0, r0, t0, ok0);
        chk("post_rst_rd", {ok0, r0, d0}, {1'b1, 2'b00, 32'h0bad_cafe});
        read_txn(1, 16'h0020, d1, r1, t1, ok1);
        chk("abandoned_wr", {ok1, d1}, {1'b1, 32'h0});

        repeat (2) @(posedge aclk);
        #1;
        chk("stray_resp", stray, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
